hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised hazard-detection unit for the five-stage MIPS pipeline with a per-register countdown scoreboard. It replaces per-stage Tnew/address comparison with a registered scoreboard, so pipeline depth and result latency are set by parameters and never by added comparators. It sits beside the D stage and holds the decode stage (stall) for three hazard classes. GPR read-after-write hazards use the Tuse/Tnew rule. HI/LO accesses are held while the multiply/divide unit is busy, with per-operation latency. `eret` is held while an EPC write is still in flight.

## Interface
- `NREG`, 32, number of architectural GPRs; entry 0 is hardwired never-pending
- `AW`, 5, GPR address width (clog2 NREG)
- `TW`, 3, Tnew/Tuse width; Tuse value of all-ones means "operand not read"
- `MULT_LAT`, 5, HI/LO busy cycles after a mult/multu start
- `DIV_LAT`, 10, HI/LO busy cycles after a div/divu start
- `EPC_ADDR`, 14, CP0 register number of EPC
- `EPC_WIN`, 2, cycles after an EPC-writing mtc0 issues during which `eret` must wait

Ports:
- `clk` in 1: single clock, all state on rising edge
- `reset` in 1: asynchronous, active-low; clears all state
- `issue_valid` in 1: the D-stage instruction is valid; the block qualifies it internally as issue = `issue_valid & ~stall`
- `rs_addr`, `rt_addr` in AW: D-stage source registers
- `rs_tuse`, `rt_tuse` in TW: cycles until each operand is needed; all-ones = unused
- `wr_en` in 1, `wr_addr` in AW, `wr_tnew` in TW: D-stage instruction writes `wr_addr`; result is forwardable `wr_tnew` cycles after it enters E
- `hilo_use` in 1: D-stage instruction is mfhi/mflo/mthi/mtlo/mult/div family
- `md_start` in 1, `md_div` in 1: E-stage starts the MD unit; `md_div`=1 selects DIV_LAT
- `mtc0_issue` in 1, `mtc0_addr` in 5: D-stage instruction is mtc0 to `mtc0_addr`
- `eret_d` in 1: D-stage instruction is eret
- `flush` in 1: exception/eret pipeline flush
- `stall` out 1: OR of the four cause outputs
- `stall_rs`, `stall_rt`, `stall_hilo`, `stall_eret` out 1 each: individual causes, for debug and for the bench
- `md_busy` out 1: `md_start | (md_cnt != 0)`

## Operation
- State:
  - `cnt[1..NREG-1]` (TW bits each): cycles until the pending result of that register is forwardable.
  - `md_cnt`: ceil(log2(DIV_LAT+1)) bits, sized for the larger of the two latencies.
  - `epc_cnt`: 2-bit minimum, sized for EPC_WIN.
- GPR rule (combinational): `stall_rs = (rs_addr!=0) & (cnt[rs_addr] > rs_tuse)`; `stall_rt` likewise. Unused operands (all-ones Tuse) can never stall.
- Scoreboard update each edge:
  - Every nonzero entry decrements by 1 and saturates at 0.
  - If issue & `wr_en` & `wr_addr`!=0, then `cnt[wr_addr] <= wr_tnew`. The issue write wins over a decrement of the same entry.
- HI/LO:
  - `stall_hilo = hilo_use & md_busy`.
  - On `md_start`, `md_cnt <= md_div ? DIV_LAT : MULT_LAT`. A new start overrides any count in progress.
  - Otherwise a nonzero `md_cnt` decrements.
- EPC/eret:
  - `stall_eret = eret_d & (epc_cnt != 0)`.
  - An issue with `mtc0_issue & mtc0_addr==EPC_ADDR` loads `epc_cnt <= EPC_WIN`.
  - Otherwise a nonzero `epc_cnt` decrements.
- Flush:
  - Clears all `cnt[]` and `epc_cnt` on the next edge. Flushed producers never write back.
  - `md_cnt` is untouched, because the MD unit completes regardless.
  - Flush has priority over a same-cycle issue write.
- Write-after-write to the same register: the newer issue overwrites the entry. This is correct because the older producer is always earlier in the pipeline.

## Timing
- Reset values: all `cnt`, `md_cnt` and `epc_cnt` are 0. Hence `stall`, all cause outputs and `md_busy` are 0 while `reset` is low, except that `md_busy` follows `md_start` combinationally.
- Stall outputs are combinational from current state plus D-stage inputs, with zero latency. The scoreboard reflects an issue from the next cycle onward.
- A producer with Tnew=n and a consumer with Tuse=u, issued back-to-back, cost max(0, n-u) stall cycles.
- MD: a start in cycle t gives `md_busy` high during cycles t..t+LAT, i.e. LAT+1 cycles.
- Reset asserted mid-operation discards all pending state immediately (asynchronous); no stall survives the reset.

## Test plan
- Load-use: lw $8 issued (`wr_tnew`=2), then add reading $8 (`rs_tuse`=1) → `stall_rs` high for exactly 1 cycle, then the add issues.
- Branch after ALU: addu $9 (`wr_tnew`=1), then beq on $9 (`rt_tuse`=0) → 1 stall cycle. With one independent instruction between them → 0 stalls.
- $0 and unused operand:
  - Write to $0 with `wr_tnew`=2, then a read of $0 → never stalls.
  - `rs_tuse`=7 with pending `cnt`=2 → no stall.
- Divide: `md_start` with `md_div`=1 at cycle 10 and mflo held in D → `stall_hilo` high in cycles 10..20 (11 cycles). mult with default latency → 6 cycles.
- eret after mtc0 $14: mtc0 issues at cycle 5 → eret stalled in cycles 6–7 and issues in cycle 8. mtc0 to $12 → no stall.
- Flush/reset:
  - Flush while a lw is pending, then a consumer → 0 stalls.
  - `reset` low mid-divide → `md_busy` and `stall` are 0 within the same cycle and stay 0 after release.

Source files
------------

// File: rtl/hazard_scoreboard_if.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard_if
// Groups the D-stage hazard query, the E-stage multiply/divide start and the
// flush signal into one bundle, together with the stall causes returned to
// the pipeline.
//   master : pipeline side. Drives the D-stage fields, md_start/md_div and
//            flush. Receives stall, the four stall causes and md_busy.
//   slave  : scoreboard side. The same signals with the opposite directions.
// ---------------------------------------------------------------------------
interface hazard_scoreboard_if #(
    parameter int AW = 5,
    parameter int TW = 3
);
    logic          issue_valid;
    logic [AW-1:0] rs_addr;
    logic [AW-1:0] rt_addr;
    logic [TW-1:0] rs_tuse;
    logic [TW-1:0] rt_tuse;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [TW-1:0] wr_tnew;
    logic          hilo_use;
    logic          md_start;
    logic          md_div;
    logic          mtc0_issue;
    logic [4:0]    mtc0_addr;
    logic          eret_d;
    logic          flush;
    logic          stall;
    logic          stall_rs;
    logic          stall_rt;
    logic          stall_hilo;
    logic          stall_eret;
    logic          md_busy;

    modport master (
        output issue_valid, rs_addr, rt_addr, rs_tuse, rt_tuse,
               wr_en, wr_addr, wr_tnew, hilo_use, md_start, md_div,
               mtc0_issue, mtc0_addr, eret_d, flush,
        input  stall, stall_rs, stall_rt, stall_hilo, stall_eret, md_busy
    );

    modport slave (
        input  issue_valid, rs_addr, rt_addr, rs_tuse, rt_tuse,
               wr_en, wr_addr, wr_tnew, hilo_use, md_start, md_div,
               mtc0_issue, mtc0_addr, eret_d, flush,
        output stall, stall_rs, stall_rt, stall_hilo, stall_eret, md_busy
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
// Decode-stage hazard unit for the five-stage MIPS pipeline. It keeps one
// countdown per GPR. Each countdown gives the number of cycles until that
// register's pending result can be forwarded. It also keeps a busy countdown
// for the multiply/divide unit and a short window after an EPC write.
// The D stage is held for three reasons:
//   - a GPR read-after-write hazard (Tuse/Tnew rule),
//   - a HI/LO access while the multiply/divide unit is busy,
//   - an eret while an EPC write is still in flight.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-low clear of all state
//   hz    : slave side of hazard_scoreboard_if. It carries the D-stage query,
//           md_start/md_div and flush in, and stall, the four stall causes
//           and md_busy out.
// The stall outputs are combinational on purpose. The decode stage needs
// them in the same cycle as the query.
// ---------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int NREG     = 32,
    parameter int AW       = 5,
    parameter int TW       = 3,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int EPC_ADDR = 14,
    parameter int EPC_WIN  = 2
) (
    input logic                clk,
    input logic                reset,
    hazard_scoreboard_if.slave hz
);
    localparam int MD_MAX = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
    localparam int MDW    = $clog2(MD_MAX + 1);
    localparam int EW_RAW = $clog2(EPC_WIN + 1);
    localparam int EW     = (EW_RAW < 2) ? 2 : EW_RAW;

    logic [TW-1:0]  cnt_r [NREG];
    logic [MDW-1:0] md_cnt_r;
    logic [EW-1:0]  epc_cnt_r;

    logic stall_rs_s;
    logic stall_rt_s;
    logic stall_hilo_s;
    logic stall_eret_s;
    logic stall_s;
    logic md_busy_s;
    logic issue_s;
    logic epc_load_s;

    // Hazard causes derived from the current scoreboard state and the D-stage query
    always_comb begin
        stall_rs_s   = 1'b0;
        stall_rt_s   = 1'b0;
        md_busy_s    = 1'b0;
        stall_hilo_s = 1'b0;
        stall_eret_s = 1'b0;
        // An all-ones Tuse can never be exceeded by a TW-bit count.
        // This is why an unused operand never stalls.
        if (hz.rs_addr != {AW{1'b0}}) begin
            stall_rs_s = (cnt_r[hz.rs_addr] > hz.rs_tuse);
        end else begin
            stall_rs_s = 1'b0;
        end
        if (hz.rt_addr != {AW{1'b0}}) begin
            stall_rt_s = (cnt_r[hz.rt_addr] > hz.rt_tuse);
        end else begin
            stall_rt_s = 1'b0;
        end
        md_busy_s    = hz.md_start | (md_cnt_r != {MDW{1'b0}});
        stall_hilo_s = hz.hilo_use & md_busy_s;
        stall_eret_s = hz.eret_d & (epc_cnt_r != {EW{1'b0}});
    end

    assign stall_s    = stall_rs_s | stall_rt_s | stall_hilo_s | stall_eret_s;
    assign issue_s    = hz.issue_valid & ~stall_s;
    assign epc_load_s = issue_s & hz.mtc0_issue & (hz.mtc0_addr == 5'(EPC_ADDR));

    assign hz.stall      = stall_s;
    assign hz.stall_rs   = stall_rs_s;
    assign hz.stall_rt   = stall_rt_s;
    assign hz.stall_hilo = stall_hilo_s;
    assign hz.stall_eret = stall_eret_s;
    assign hz.md_busy    = md_busy_s;

    // GPR countdowns: a flush clears them, an issued write loads one, otherwise they count down to zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                cnt_r[i] <= {TW{1'b0}};
            end
        end else begin
            cnt_r[0] <= {TW{1'b0}};
            for (int i = 1; i < NREG; i++) begin
                if (hz.flush) begin
                    // Flushed producers never write back, so nothing stays pending.
                    cnt_r[i] <= {TW{1'b0}};
                end else if (issue_s && hz.wr_en && (hz.wr_addr == AW'(i))) begin
                    // A newer writer always overrides the older entry.
                    // The older producer is further down the pipe.
                    cnt_r[i] <= hz.wr_tnew;
                end else if (cnt_r[i] != {TW{1'b0}}) begin
                    cnt_r[i] <= cnt_r[i] - TW'(1'b1);
                end else begin
                    cnt_r[i] <= cnt_r[i];
                end
            end
        end
    end

    // Multiply/divide busy countdown; the unit always completes, so flush leaves it alone
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            md_cnt_r <= {MDW{1'b0}};
        end else if (hz.md_start) begin
            md_cnt_r <= hz.md_div ? MDW'(DIV_LAT) : MDW'(MULT_LAT);
        end else if (md_cnt_r != {MDW{1'b0}}) begin
            md_cnt_r <= md_cnt_r - MDW'(1'b1);
        end else begin
            md_cnt_r <= md_cnt_r;
        end
    end

    // EPC write window that holds a following eret
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            epc_cnt_r <= {EW{1'b0}};
        end else if (hz.flush) begin
            epc_cnt_r <= {EW{1'b0}};
        end else if (epc_load_s) begin
            epc_cnt_r <= EW'(EPC_WIN);
        end else if (epc_cnt_r != {EW{1'b0}}) begin
            epc_cnt_r <= epc_cnt_r - EW'(1'b1);
        end else begin
            epc_cnt_r <= epc_cnt_r;
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_hazard_scoreboard
// Runs a directed sequence and then random traffic. The reference model
// records absolute cycle numbers instead of countdowns:
//   - the cycle at which each register's result becomes forwardable,
//   - the last cycle during which the multiply/divide unit is busy,
//   - the last cycle of the EPC window.
// From these it derives the expected stall causes.
// ---------------------------------------------------------------------------
module tb_hazard_scoreboard;
    localparam int NREG     = 32;
    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;
    localparam int EPC_ADDR = 14;
    localparam int EPC_WIN  = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_scoreboard_if #(.AW(5), .TW(3)) hz ();

    hazard_scoreboard #(
        .NREG(NREG), .AW(5), .TW(3), .MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT),
        .EPC_ADDR(EPC_ADDR), .EPC_WIN(EPC_WIN)
    ) dut (
        .clk(clk),
        .reset(reset),
        .hz(hz.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int ready_at [NREG];
    int md_end;
    int epc_end;
    logic e_rs, e_rt, e_hilo, e_eret, e_stall, e_busy;
    logic o_rs, o_rt, o_hilo, o_eret;
    int n;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0b expected=%0b cyc=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs == exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int pend(input int r);
        int d;
        if (r == 0) return 0;
        d = ready_at[r] - cyc;
        return (d > 0) ? d : 0;
    endfunction

    task automatic model_clear();
        for (int r = 0; r < NREG; r++) ready_at[r] = 0;
        md_end  = -100;
        epc_end = -100;
    endtask

    task automatic model_eval();
        e_rs    = (hz.rs_addr != 0) && (pend(int'(hz.rs_addr)) > int'(hz.rs_tuse));
        e_rt    = (hz.rt_addr != 0) && (pend(int'(hz.rt_addr)) > int'(hz.rt_tuse));
        e_busy  = hz.md_start || (cyc <= md_end);
        e_hilo  = hz.hilo_use && e_busy;
        e_eret  = hz.eret_d && (cyc <= epc_end);
        e_stall = e_rs || e_rt || e_hilo || e_eret;
    endtask

    task automatic model_advance();
        logic issue;
        if (!reset) begin
            model_clear();
        end else begin
            issue = hz.issue_valid && !e_stall;
            if (hz.md_start) md_end = cyc + (hz.md_div ? DIV_LAT : MULT_LAT);
            if (hz.flush) begin
                for (int r = 0; r < NREG; r++) ready_at[r] = 0;
                epc_end = -100;
            end else begin
                if (issue && hz.wr_en && hz.wr_addr != 0)
                    ready_at[hz.wr_addr] = cyc + 1 + int'(hz.wr_tnew);
                if (issue && hz.mtc0_issue && hz.mtc0_addr == EPC_ADDR)
                    epc_end = cyc + EPC_WIN;
            end
        end
    endtask

    // Compare all outputs mid-cycle, advance the model, then step to just after the next edge
    task automatic tick();
        @(negedge clk);
        model_eval();
        check("stall_rs",   hz.stall_rs,   e_rs);
        check("stall_rt",   hz.stall_rt,   e_rt);
        check("stall_hilo", hz.stall_hilo, e_hilo);
        check("stall_eret", hz.stall_eret, e_eret);
        check("stall",      hz.stall,      e_stall);
        check("md_busy",    hz.md_busy,    e_busy);
        o_rs = hz.stall_rs; o_rt = hz.stall_rt;
        o_hilo = hz.stall_hilo; o_eret = hz.stall_eret;
        model_advance();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic idle();
        hz.issue_valid = 1'b0; hz.rs_addr = 5'd0; hz.rt_addr = 5'd0;
        hz.rs_tuse = 3'd7; hz.rt_tuse = 3'd7; hz.wr_en = 1'b0;
        hz.wr_addr = 5'd0; hz.wr_tnew = 3'd0; hz.hilo_use = 1'b0;
        hz.md_start = 1'b0; hz.md_div = 1'b0; hz.mtc0_issue = 1'b0;
        hz.mtc0_addr = 5'd0; hz.eret_d = 1'b0; hz.flush = 1'b0;
    endtask

    task automatic drain();
        idle();
        for (int k = 0; k < 12; k++) tick();
    endtask

    // Bounded global timeout so the run can never hang
    initial begin
        #1000000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        idle();
        model_clear();
        tick();
        tick();
        check("reset_stall", hz.stall, 1'b0);
        check("reset_busy", hz.md_busy, 1'b0);
        reset = 1'b1;
        tick();

        // Load-use: lw $8 (tnew 2), then add reading $8 (tuse 1)
        hz.issue_valid = 1'b1; hz.wr_en = 1'b1; hz.wr_addr = 5'd8; hz.wr_tnew = 3'd2;
        tick();
        hz.wr_addr = 5'd10; hz.wr_tnew = 3'd1; hz.rs_addr = 5'd8; hz.rs_tuse = 3'd1;
        n = 0;
        for (int k = 0; k < 6; k++) begin tick(); if (o_rs) n++; else break; end
        check_int("load_use_stalls", n, 1);
        drain();

        // Branch right after an ALU producer: 1 stall
        hz.issue_valid = 1'b1; hz.wr_en = 1'b1; hz.wr_addr = 5'd9; hz.wr_tnew = 3'd1;
        tick();
        hz.wr_en = 1'b0; hz.rt_addr = 5'd9; hz.rt_tuse = 3'd0;
        n = 0;
        for (int k = 0; k < 6; k++) begin tick(); if (o_rt) n++; else break; end
        check_int("branch_alu_stalls", n, 1);
        drain();

        // Same pair with one independent instruction between them: 0 stalls
        hz.issue_valid = 1'b1; hz.wr_en = 1'b1; hz.wr_addr = 5'd9; hz.wr_tnew = 3'd1;
        tick();
        hz.wr_en = 1'b0;
        tick();
        hz.rt_addr = 5'd9; hz.rt_tuse = 3'd0;
        n = 0;
        for (int k = 0; k < 6; k++) begin tick(); if (o_rt) n++; else break; end
        check_int("branch_gap_stalls", n, 0);
        drain();

        // Write to $0, then read $0: never stalls
        hz.issue_valid = 1'b1; hz.wr_en = 1'b1; hz.wr_addr = 5'd0; hz.wr_tnew = 3'd2;
        tick();
        hz.wr_en = 1'b0; hz.rs_addr = 5'd0; hz.rs_tuse = 3'd0;
        hz.rt_addr = 5'd0; hz.rt_tuse = 3'd0;
        tick();
        check("zero_reg_rs", o_rs, 1'b0);
        check("zero_reg_rt", o_rt, 1'b0);
        drain();

        // Unused operand (tuse 7) with a pending count of 2: no stall
        hz.issue_valid = 1'b1; hz.wr_en = 1'b1; hz.wr_addr = 5'd5; hz.wr_tnew = 3'd2;
        tick();
        hz.wr_en = 1'b0; hz.rs_addr = 5'd5; hz.rs_tuse = 3'd7;
        tick();
        check("unused_operand", o_rs, 1'b0);
        drain();

        // Divide started with mflo held in D: 11 stall cycles
        hz.issue_valid = 1'b1; hz.hilo_use = 1'b1; hz.md_start = 1'b1; hz.md_div = 1'b1;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (o_hilo) n++;
            hz.md_start = 1'b0;
        end
        check_int("div_hilo_stalls", n, DIV_LAT + 1);

        // Mult with the default latency: 6 stall cycles
        hz.md_start = 1'b1; hz.md_div = 1'b0;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (o_hilo) n++;
            hz.md_start = 1'b0;
        end
        check_int("mult_hilo_stalls", n, MULT_LAT + 1);
        drain();

        // eret after mtc0 to EPC: 2 stall cycles
        hz.issue_valid = 1'b1; hz.mtc0_issue = 1'b1; hz.mtc0_addr = 5'd14;
        tick();
        hz.mtc0_issue = 1'b0; hz.eret_d = 1'b1;
        n = 0;
        for (int k = 0; k < 6; k++) begin tick(); if (o_eret) n++; else break; end
        check_int("eret_epc_stalls", n, EPC_WIN);
        drain();

        // eret after mtc0 to Status ($12): no stall
        hz.issue_valid = 1'b1; hz.mtc0_issue = 1'b1; hz.mtc0_addr = 5'd12;
        tick();
        hz.mtc0_issue = 1'b0; hz.eret_d = 1'b1;
        tick();
        check("eret_status", o_eret, 1'b0);
        drain();

        // Flush while a lw is pending, then a consumer: 0 stalls
        hz.issue_valid = 1'b1; hz.wr_en = 1'b1; hz.wr_addr = 5'd8; hz.wr_tnew = 3'd2;
        tick();
        idle(); hz.flush = 1'b1;
        tick();
        hz.flush = 1'b0; hz.issue_valid = 1'b1; hz.rs_addr = 5'd8; hz.rs_tuse = 3'd0;
        n = 0;
        for (int k = 0; k < 6; k++) begin tick(); if (o_rs) n++; else break; end
        check_int("flush_stalls", n, 0);
        drain();

        // Reset asserted in the middle of a divide
        hz.md_start = 1'b1; hz.md_div = 1'b1;
        tick();
        hz.md_start = 1'b0; hz.hilo_use = 1'b1; hz.issue_valid = 1'b1;
        tick();
        tick();
        #2;
        reset = 1'b0;
        model_clear();
        #1;
        check("reset_mid_busy", hz.md_busy, 1'b0);
        check("reset_mid_stall", hz.stall, 1'b0);
        tick();
        reset = 1'b1;
        tick();
        check("post_reset_hilo", o_hilo, 1'b0);
        tick();
        check("post_reset_busy", hz.md_busy, 1'b0);
        drain();

        // Random traffic against the model
        for (int k = 0; k < 500; k++) begin
            hz.issue_valid = ($urandom_range(0, 3) != 0);
            hz.rs_addr     = 5'($urandom_range(0, 3));
            hz.rt_addr     = 5'($urandom_range(0, 3));
            hz.rs_tuse     = 3'($urandom_range(0, 7));
            hz.rt_tuse     = 3'($urandom_range(0, 7));
            hz.wr_en       = ($urandom_range(0, 1) != 0);
            hz.wr_addr     = 5'($urandom_range(0, 3));
            hz.wr_tnew     = 3'($urandom_range(0, 4));
            hz.hilo_use    = ($urandom_range(0, 5) == 0);
            hz.md_start    = ($urandom_range(0, 11) == 0);
            hz.md_div      = ($urandom_range(0, 1) != 0);
            hz.mtc0_issue  = ($urandom_range(0, 7) == 0);
            hz.mtc0_addr   = ($urandom_range(0, 1) != 0) ? 5'd14 : 5'd12;
            hz.eret_d      = ($urandom_range(0, 5) == 0);
            hz.flush       = ($urandom_range(0, 19) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
